// File: rtl/pong_pkg.sv
// Shared pong constants: match-state encodings, control key bytes and the blank digit pattern.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [7:0] KEY_START   = 8'd103;  // 'g'
  localparam logic [7:0] KEY_RESTART = 8'd98;   // 'b'
  localparam logic [6:0] SEG_BLANK   = 7'h7F;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_decoder
  import pong_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_keeper.sv
// Match score tracking and play/serve-hold/game-over sequencing for two players,
// with registered seven-segment score digits.
module score_keeper
  import pong_pkg::*;
#(
  parameter int         WIN_SCORE   = 7,
  parameter logic [7:0] START       = KEY_START,
  parameter logic [7:0] RESTART     = KEY_RESTART,
  parameter int         HOLD_CYCLES = 25_000_000,
  parameter int         HOLD_W      = 25
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic [7:0] i_key_byte,
  input  logic       i_p1_scored,
  input  logic       i_p2_scored,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [6:0] o_p1_seg,
  output logic [6:0] o_p2_seg,
  output logic       o_play_enable,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [1:0] o_state
);

  localparam logic [3:0]        WIN_Q     = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        p1_q, p1_d, p2_q, p2_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              winner_q, winner_d;
  logic              p1_prev_q, p2_prev_q;
  logic [6:0]        p1_seg_q, p2_seg_q;
  logic [6:0]        p1_seg_d, p2_seg_d;
  logic              p1_edge, p2_edge;
  logic [3:0]        p1_inc, p2_inc;

  assign p1_edge = i_p1_scored & ~p1_prev_q;
  assign p2_edge = i_p2_scored & ~p2_prev_q;
  assign p1_inc  = p1_q + 4'd1;
  assign p2_inc  = p2_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    if (i_key_byte == RESTART) begin
      state_d  = ST_IDLE;
      p1_d     = 4'd0;
      p2_d     = 4'd0;
      hold_d   = '0;
      winner_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (i_key_byte == START) state_d = ST_PLAY;
        ST_PLAY: begin
          // p1 wins a simultaneous rise; p2's edge is simply dropped.
          if (p1_edge) begin
            p1_d = p1_inc;
            if (p1_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end else if (p2_edge) begin
            p2_d = p2_inc;
            if (p2_inc == WIN_Q) begin
              state_d  = ST_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) state_d = ST_PLAY;
          else              hold_d  = hold_q - HOLD_W'(1);
        end
        ST_OVER: ;
      endcase
    end
  end

  seg7_decoder u_p1_dec (.digit_i(p1_q), .seg_o(p1_seg_d));
  seg7_decoder u_p2_dec (.digit_i(p2_q), .seg_o(p2_seg_d));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      p1_q      <= 4'd0;
      p2_q      <= 4'd0;
      hold_q    <= '0;
      winner_q  <= 1'b0;
      p1_prev_q <= 1'b0;
      p2_prev_q <= 1'b0;
      p1_seg_q  <= 7'b1000000;
      p2_seg_q  <= 7'b1000000;
    end else begin
      state_q   <= state_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      hold_q    <= hold_d;
      winner_q  <= winner_d;
      p1_prev_q <= i_p1_scored;
      p2_prev_q <= i_p2_scored;
      p1_seg_q  <= p1_seg_d;
      p2_seg_q  <= p2_seg_d;
    end
  end

  assign o_p1_score    = p1_q;
  assign o_p2_score    = p2_q;
  assign o_p1_seg      = p1_seg_q;
  assign o_p2_seg      = p2_seg_q;
  assign o_play_enable = (state_q == ST_PLAY);
  assign o_game_over   = (state_q == ST_OVER);
  assign o_winner      = winner_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed match scenarios followed by random play,
// checked every cycle against a behavioural match model.
module tb_score_keeper;

  localparam int HC  = 4;
  localparam int WIN = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key = 8'd0;
  logic       p1s = 1'b0, p2s = 1'b0;
  logic [3:0] p1_score, p2_score;
  logic [6:0] p1_seg, p2_seg;
  logic       play_en, game_over, winner;
  logic [1:0] state;

  always #5 clk = ~clk;

  score_keeper #(.WIN_SCORE(WIN), .START(8'd103), .RESTART(8'd98),
                 .HOLD_CYCLES(HC), .HOLD_W(3)) dut (
    .i_CLK(clk), .i_RST(rst), .i_key_byte(key),
    .i_p1_scored(p1s), .i_p2_scored(p2s),
    .o_p1_score(p1_score), .o_p2_score(p2_score),
    .o_p1_seg(p1_seg), .o_p2_seg(p2_seg),
    .o_play_enable(play_en), .o_game_over(game_over),
    .o_winner(winner), .o_state(state)
  );

  typedef struct {
    int         st, s1, s2, w;
    logic [6:0] g1, g2;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Behavioural model: match phase 0..3, scores, remaining hold cycles.
  int         m_st = 0, m_s1 = 0, m_s2 = 0, m_w = 0, m_left = 0;
  bit         m_pv1 = 0, m_pv2 = 0;
  logic [6:0] m_g1 = 7'h40, m_g2 = 7'h40;
  logic [6:0] seg_tab [16];

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;
  end

  task automatic score_point(input int who);
    if (who == 1) m_s1++; else m_s2++;
    if ((who == 1 ? m_s1 : m_s2) == WIN) begin
      m_st = 3;
      m_w  = (who == 1) ? 0 : 1;
    end else begin
      m_st   = 2;
      m_left = HC;
    end
  endtask

  task automatic step(input logic [7:0] k, input logic a, input logic b, input logic r);
    exp_t e;
    bit e1, e2;
    logic [6:0] n1, n2;
    @(negedge clk);
    key = k; p1s = a; p2s = b; rst = r;
    if (r) begin
      m_st = 0; m_s1 = 0; m_s2 = 0; m_w = 0; m_left = 0;
      m_pv1 = 0; m_pv2 = 0; m_g1 = 7'h40; m_g2 = 7'h40;
    end else begin
      e1 = a && !m_pv1;
      e2 = b && !m_pv2;
      n1 = seg_tab[m_s1];
      n2 = seg_tab[m_s2];
      if (k == 8'd98) begin
        m_st = 0; m_s1 = 0; m_s2 = 0; m_w = 0; m_left = 0;
      end else if (m_st == 0) begin
        if (k == 8'd103) m_st = 1;
      end else if (m_st == 1) begin
        if (e1) score_point(1);
        else if (e2) score_point(2);
      end else if (m_st == 2) begin
        m_left--;
        if (m_left == 0) m_st = 1;
      end
      m_pv1 = a; m_pv2 = b; m_g1 = n1; m_g2 = n2;
    end
    e.st = m_st; e.s1 = m_s1; e.s2 = m_s2; e.w = m_w; e.g1 = m_g1; e.g2 = m_g2;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: each cycle's outputs are compared to the oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state", int'(state), e.st);
      chk("p1_score", int'(p1_score), e.s1);
      chk("p2_score", int'(p2_score), e.s2);
      chk("p1_seg", int'(p1_seg), int'(e.g1));
      chk("p2_seg", int'(p2_seg), int'(e.g2));
      chk("play_enable", int'(play_en), int'(e.st == 1));
      chk("game_over", int'(game_over), int'(e.st == 3));
      chk("winner", int'(winner), e.w);
    end
  end

  initial begin
    int r;
    logic [7:0] k;
    logic a, b, rr;
    step(8'd0, 0, 0, 1);
    step(8'd0, 0, 0, 1);
    idle(2);
    // Scoring ignored while idle.
    step(8'd0, 1, 0, 0); idle(2);
    // Start, then a held p1 level counts once and serves a hold.
    step(8'd103, 0, 0, 0); idle(1);
    for (int i = 0; i < 10; i++) step(8'd0, 1, 0, 0);
    idle(4);
    // Fresh match: simultaneous rise scores only p1.
    step(8'd98, 0, 0, 0); step(8'd103, 0, 0, 0); idle(1);
    step(8'd0, 1, 1, 0); idle(6);
    // Seven p2 points end the match with p2 as winner.
    for (int i = 0; i < 7; i++) begin
      step(8'd0, 0, 1, 0); idle(6);
    end
    idle(2);
    step(8'd103, 0, 0, 0); idle(2);
    step(8'd98, 0, 0, 0); idle(2);
    // Reset in the middle of a serve hold.
    step(8'd103, 0, 0, 0); idle(1);
    step(8'd0, 1, 0, 0); step(8'd0, 0, 0, 0);
    step(8'd0, 0, 0, 1); idle(8);
    // Random play.
    a = 0; b = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 30)       k = 8'd103;
      else if (r < 33)  k = 8'd98;
      else if (r < 80)  k = 8'($urandom_range(0, 255));
      else              k = 8'd0;
      if ($urandom_range(0, 3) == 0) a = ~a;
      if ($urandom_range(0, 3) == 0) b = ~b;
      rr = ($urandom_range(0, 399) == 0);
      step(k, a, b, rr);
    end
    idle(2);
    @(posedge clk); #5;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
